score_digits: RTL and testbench
===============================

SCORE_DIGITS -- requirements
Module: score_digits

Interface
REQ-001 Parameter SCORE_W, default 8, width of the binary score input.
REQ-002 Parameter NUM_DIGITS, default 3, number of BCD digits produced; 10^NUM_DIGITS > 2^SCORE_W shall hold, and elaboration shall fail otherwise.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Score  input  SCORE_W  binary score to convert.
REQ-006 ScoreValid  input  1  one-cycle request strobe; Score is sampled when it is high.
REQ-007 Digits  output  4*NUM_DIGITS  BCD digits, ones digit in bits [3:0]; each nibble drives one digit_ssd Value port.
REQ-008 Blank  output  NUM_DIGITS  per-digit leading-zero blank flag; bit i pairs with nibble i.
REQ-009 Busy  output  1  high while a conversion is in progress.
REQ-010 Done  output  1  one-cycle pulse when Digits/Blank update.

Function
REQ-011 Conversion shall use shift-add-3 (double dabble), one bit per clock, MSB first.
REQ-012 The FSM shall have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: on ScoreValid=1, capture Score and a bit counter of SCORE_W, clear the BCD accumulator, and go to SHIFT.
REQ-014 SHIFT: each cycle, add 3 to every accumulator nibble >= 5, shift left one bit taking in the shift-register MSB, and decrement the counter; go to DONE after the SCORE_W-th shift.
REQ-015 DONE: register the accumulator into Digits and the computed Blank into Blank, and assert Done for exactly this cycle.
REQ-016 Latency: Digits, Blank and Done shall become valid exactly SCORE_W+1 rising edges after the accepting edge (9 for the defaults).
REQ-017 Busy shall be high in SHIFT and DONE and low in IDLE.
REQ-018 Digits and Blank shall hold their last value between conversions.
REQ-019 Blank: bit i = 1 iff nibble i and every higher nibble are zero, for i >= 1.
REQ-020 Blank bit 0 shall always be 0, so a score of 0 displays "0".
REQ-021 ScoreValid while Busy shall be stored in a one-deep pending buffer; a later request overwrites an earlier one (latest wins).
REQ-022 Leaving DONE with ScoreValid=1 in that same cycle: start that Score directly in SHIFT, and clear pending.
REQ-023 Leaving DONE otherwise, with pending set: start the pending score in SHIFT, and clear pending.
REQ-024 Leaving DONE otherwise: go to IDLE.
REQ-025 Score values up to 2^SCORE_W-1 shall convert exactly; no saturation is required.

Reset
REQ-026 Reset shall take effect asynchronously: state=IDLE, Digits=0, Blank={1..1,0} (3'b110 for the defaults), Busy=0, Done=0, pending cleared, counter and accumulator zeroed.
REQ-027 Reset mid-conversion shall abort the conversion with no Done pulse; after deassertion only a new ScoreValid starts work.

Structure
REQ-028 FSM state encoding, the BCD nibble width (4) and the add-3 threshold (5) shall live in a shared display package used by the character and score blocks.
REQ-029 One sub-module is natural: bcd_adjust, a combinational per-nibble ">=5 then +3" cell instantiated NUM_DIGITS times.
REQ-030 All outputs shall be registered.

Verification
REQ-031 Score=0 pulse from IDLE -> 9 edges later Done=1, Digits=0x000, Blank=3'b110.
REQ-032 Score=255 -> Digits=0x255, Blank=3'b000, Done high for exactly one cycle, Busy high for 9 cycles.
REQ-033 Score=7 then Score=42 and Score=99 both during Busy -> first Done shows 0x007/Blank 3'b110, second Done shows 0x099/Blank 3'b100, and there is no third Done.
REQ-034 ScoreValid with 128 in the DONE cycle while 50 is pending -> next result 0x128, pending cleared, and 50 is never shown.
REQ-035 Reset asserted at the 4th SHIFT of Score=200 -> outputs return to reset values immediately, with no Done until a new request.
REQ-036 Exhaustive sweep of 0..255 back-to-back -> every Digits matches the decimal reference model, and Blank matches REQ-019/REQ-020.

Source files
------------

// File: rtl/score_digits_pkg.sv
// Shared display constants: FSM encoding, BCD nibble geometry and the add-3 rule.
package score_digits_pkg;
   localparam int         NIBBLE_W    = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic [NIBBLE_W-1:0] add3(input logic [NIBBLE_W-1:0] n);
      return (n >= ADD3_THRESH) ? n + 4'd3 : n;
   endfunction
endpackage

// File: rtl/score_digits_if.sv
// Request/result bundle between a score source and the binary-to-BCD converter.
interface score_digits_if
   import score_digits_pkg::*;
#(
   parameter int SCORE_W    = 8,
   parameter int NUM_DIGITS = 3
);
   logic [SCORE_W-1:0]             Score;
   logic                           ScoreValid;
   logic [NIBBLE_W*NUM_DIGITS-1:0] Digits;
   logic [NUM_DIGITS-1:0]          Blank;
   logic                           Busy;
   logic                           Done;

   modport master (output Score, ScoreValid, input Digits, Blank, Busy, Done);
   modport slave  (input Score, ScoreValid, output Digits, Blank, Busy, Done);
endinterface

// File: rtl/score_digits_bcd_adjust.sv
// One double-dabble correction cell: a nibble of 5 or more gets 3 added before the shift.
module score_digits_bcd_adjust
   import score_digits_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble_in,
   output logic [NIBBLE_W-1:0] nibble_out
);
   assign nibble_out = add3(nibble_in);
endmodule

// File: rtl/score_digits.sv
// Binary score to BCD digits via shift-add-3, one bit per clock, with a one-deep
// latest-wins request buffer and leading-zero blanking.
//   state | meaning
//   IDLE  | waiting for a request
//   SHIFT | adjusting and shifting one score bit per cycle
//   DONE  | publishing the result, then chaining the next request if any
module score_digits
   import score_digits_pkg::*;
#(
   parameter int SCORE_W    = 8,
   parameter int NUM_DIGITS = 3
)(
   input  logic           clk,
   input  logic           reset,
   score_digits_if.slave  bus
);
   localparam int ACC_W = NIBBLE_W * NUM_DIGITS;
   localparam int CNT_W = $clog2(SCORE_W + 1);
   localparam logic [CNT_W-1:0]      CNT_INIT    = CNT_W'(SCORE_W);
   localparam logic [NUM_DIGITS-1:0] BLANK_RESET = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

   if (10**NUM_DIGITS <= 2**SCORE_W) begin : g_range_bad
      $error("NUM_DIGITS too small to hold every SCORE_W-bit score");
   end

   logic [1:0]            state;
   logic [SCORE_W-1:0]    sr;
   logic [SCORE_W-1:0]    pend_score;
   logic                  pend;
   logic [CNT_W-1:0]      cnt;
   logic [ACC_W-1:0]      acc;
   logic [ACC_W-1:0]      acc_adj;
   logic [ACC_W-1:0]      digits_q;
   logic [NUM_DIGITS-1:0] blank_q;
   logic [NUM_DIGITS-1:0] blank_calc;
   logic                  busy_q;
   logic                  done_q;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      score_digits_bcd_adjust u_adj (
         .nibble_in  (acc[g*NIBBLE_W +: NIBBLE_W]),
         .nibble_out (acc_adj[g*NIBBLE_W +: NIBBLE_W])
      );
   end

   // Walk down from the top digit; a digit blanks only while everything above it is zero too.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      blank_calc = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero    = upper_zero & (acc[i*NIBBLE_W +: NIBBLE_W] == '0);
         blank_calc[i] = upper_zero;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         sr         <= '0;
         pend_score <= '0;
         pend       <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         digits_q   <= '0;
         blank_q    <= BLANK_RESET;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.ScoreValid) begin
                  sr     <= bus.Score;
                  cnt    <= CNT_INIT;
                  acc    <= '0;
                  state  <= ST_SHIFT;
                  busy_q <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (bus.ScoreValid) begin
                  pend       <= 1'b1;
                  pend_score <= bus.Score;
               end
               acc <= {acc_adj[ACC_W-2:0], sr[SCORE_W-1]};
               sr  <= sr << 1;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= ST_DONE;
            end
            ST_DONE: begin
               digits_q <= acc;
               blank_q  <= blank_calc;
               done_q   <= 1'b1;
               // A request arriving right now beats the buffered one.
               if (bus.ScoreValid) begin
                  sr    <= bus.Score;
                  cnt   <= CNT_INIT;
                  acc   <= '0;
                  pend  <= 1'b0;
                  state <= ST_SHIFT;
               end else if (pend) begin
                  sr    <= pend_score;
                  cnt   <= CNT_INIT;
                  acc   <= '0;
                  pend  <= 1'b0;
                  state <= ST_SHIFT;
               end else begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Digits = digits_q;
   assign bus.Blank  = blank_q;
   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
endmodule

// File: tb/tb_score_digits.sv
// Directed bench for score_digits: expectations queued at issue time, checked by a Done monitor.
module tb_score_digits;
   localparam int SW = 8;
   localparam int ND = 3;

   typedef struct packed {
      logic [11:0] d;
      logic [2:0]  b;
   } exp_t;

   logic clk;
   logic reset;
   score_digits_if #(.SCORE_W(SW), .NUM_DIGITS(ND)) bus ();

   score_digits #(.SCORE_W(SW), .NUM_DIGITS(ND)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   exp_t q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input int v);
      exp_t e;
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      e.d = {h, t, o};
      e.b = {h == 4'd0, (h == 4'd0) && (t == 4'd0), 1'b0};
      return e;
   endfunction

   // Caller sits at a negedge; the request is taken by the following rising edge.
   task automatic issue(input int s, input bit expect_it);
      bus.Score      = 8'(s);
      bus.ScoreValid = 1'b1;
      if (expect_it) q.push_back(model(s));
      @(negedge clk);
      bus.ScoreValid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.Done === 1'b1) begin
            n_done++;
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got Digits %0h with no expected result", bus.Digits);
            end else begin
               e = q.pop_front();
               check("digits", 32'(bus.Digits), 32'(e.d));
               check("blank", 32'(bus.Blank), 32'(e.b));
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int k;
      int busy_cnt;
      int done_cnt;
      int d0;

      reset          = 1'b1;
      bus.Score      = '0;
      bus.ScoreValid = 1'b0;
      idle(3);
      check("rst_digits", 32'(bus.Digits), 32'h000);
      check("rst_blank", 32'(bus.Blank), 32'b110);
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_done", 32'(bus.Done), 32'd0);
      reset = 1'b0;
      idle(2);

      // Score 0 from IDLE, latency counted from the accepting edge.
      issue(0, 1'b1);
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.Done === 1'b1) begin
            k = i;
            break;
         end
      end
      check("latency_zero", 32'(k), 32'd9);

      // Score 255: Busy width and Done width.
      issue(255, 1'b1);
      busy_cnt = (bus.Busy === 1'b1) ? 1 : 0;
      done_cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.Busy === 1'b1) busy_cnt++;
         if (bus.Done === 1'b1) done_cnt++;
      end
      check("busy_cycles", 32'(busy_cnt), 32'd9);
      check("done_cycles", 32'(done_cnt), 32'd1);
      check("idle_busy", 32'(bus.Busy), 32'd0);

      // 7 accepted, 42 then 99 arrive during Busy: only 99 survives.
      d0 = n_done;
      issue(7, 1'b1);
      idle(2);
      issue(42, 1'b0);
      idle(1);
      issue(99, 1'b1);
      idle(30);
      check("latest_wins_dones", 32'(n_done - d0), 32'd2);

      // 50 pending, 128 arrives in the DONE cycle of 10: 128 wins, 50 never shows.
      d0 = n_done;
      issue(10, 1'b1);
      idle(2);
      issue(50, 1'b0);
      idle(5);
      check("done_state_busy", 32'(bus.Busy), 32'd1);
      issue(128, 1'b1);
      idle(30);
      check("done_direct_dones", 32'(n_done - d0), 32'd2);
      check("after_128_digits", 32'(bus.Digits), 32'h128);

      // Reset during the 4th shift of 200 aborts with no Done.
      d0 = n_done;
      issue(200, 1'b0);
      idle(3);
      reset = 1'b1;
      #1;
      check("abort_digits", 32'(bus.Digits), 32'h000);
      check("abort_blank", 32'(bus.Blank), 32'b110);
      check("abort_busy", 32'(bus.Busy), 32'd0);
      check("abort_done", 32'(bus.Done), 32'd0);
      idle(2);
      reset = 1'b0;
      idle(20);
      check("abort_no_done", 32'(n_done - d0), 32'd0);
      check("abort_stays_idle", 32'(bus.Busy), 32'd0);

      // Back-to-back sweep: each request lands in the previous DONE cycle.
      d0 = n_done;
      for (int v = 0; v < 256; v++) begin
         issue(v, 1'b1);
         idle(8);
      end
      idle(15);
      check("sweep_dones", 32'(n_done - d0), 32'd256);
      check("queue_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
